inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised dual-lane instruction queue between the fetch interface and the decode stage; successor to the single-slot IF/ID register.
- Accepts 0, 1 or 2 fetched instructions per cycle and presents the oldest 0, 1 or 2 instructions to a master/slave decode pair.
- Lets fetch run ahead of decode stalls; flushed on branch redirect or exception.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- DATA_W, 32, instruction word width.
- ADDR_W, 32, PC address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  discard all entries (branch/exception redirect).
- push_1  in  1  lane-1 instruction valid from fetch.
- push_2  in  1  lane-2 instruction valid; legal only with push_1.
- push_data_1  in  DATA_W  lane-1 instruction.
- push_data_2  in  DATA_W  lane-2 instruction.
- push_addr_1  in  ADDR_W  lane-1 PC.
- push_addr_2  in  ADDR_W  lane-2 PC; expected push_addr_1+4, not checked.
- pop_1  in  1  master decode consumes head entry.
- pop_2  in  1  slave decode consumes head+1; legal only with pop_1.
- out_valid_1  out  1  head entry present.
- out_data_1  out  DATA_W  head instruction.
- out_addr_1  out  ADDR_W  head PC.
- out_valid_2  out  1  head+1 entry present.
- out_data_2  out  DATA_W  head+1 instruction.
- out_addr_2  out  ADDR_W  head+1 PC.
- full  out  1  fewer than 2 free entries.
- empty  out  1  count == 0.
- count  out  clog2(DEPTH)+1  occupied entries.
- push_drop  out  1  one-cycle pulse: push attempted while full.

Behaviour:
- Storage: DEPTH-entry circular buffer of {data, addr}; head/tail pointers clog2(DEPTH) bits, wrap modulo DEPTH; registered count.
- Reset (rst=1 at clk edge): head=tail=count=0; full=0, empty=1, out_valid_1/2=0, push_drop=0; all data/addr outputs 0.
- Outputs are combinational from registered state only (no input-to-output paths):
  - out_valid_1 = count>=1; out_valid_2 = count>=2.
  - out_data_n/out_addr_n = 0 when out_valid_n=0.
  - full = (DEPTH-count)<2.
  - empty = (count==0).
- Push-to-visible latency: 1 cycle. An entry pushed at edge N appears on outputs after edge N.
- No bypass: an empty queue shows out_valid_1=0 in the push cycle.
- Push acceptance:
  - Evaluated on registered full; same-cycle pops do not free space for same-cycle pushes.
  - full=0: push_1 writes lane 1 at tail; push_2 writes lane 2 at tail+1; tail advances by 1 or 2.
  - full=1 and push_1=1: nothing written; push_drop=1 the next cycle (registered); pointers unchanged.
- Pop:
  - pop_1 advances head by 1; pop_1&pop_2 advances head by 2.
  - A pop on a lane whose out_valid is 0 is ignored for that lane. pop_2 without pop_1 is ignored.
- Simultaneous push and pop: count_next = count + pushes_accepted − pops_accepted.
- Order is strict FIFO: lane 1 of a push is older than lane 2.
- flush (highest priority after rst): head=tail=count=0 at the edge; same-cycle push and pop are discarded; push_drop=0 next cycle.
- Illegal input push_2 without push_1: treated as no push. Bench asserts this never occurs.
- Invariants:
  - count ≤ DEPTH.
  - tail − head ≡ count mod DEPTH.
  - Occupancy DEPTH-1 yields full=1, so a single push into the last slot is never issued.

Test Plan:
- Reset then push_1 (data 0x24020001, addr 0xBFC00000) -> next cycle out_valid_1=1, out_data_1=0x24020001, out_addr_1=0xBFC00000, out_valid_2=0, count=1, empty=0.
- DEPTH=4: two dual pushes (PCs 0x100..0x10C) -> count=4, full=1. A third push_1 -> queue unchanged, push_drop=1 for exactly one cycle.
- Dual pop with count=3 -> next cycle count=1, out_addr_1=third PC. Then pop_1&pop_2 with count=1 -> count=0, empty=1, no underflow.
- Wrap-around, DEPTH=4: push/pop 1 per cycle for 10 cycles with PCs incrementing by 4 -> outputs in exact FIFO order across pointer wrap, count steady at 1.
- flush asserted with dual push and dual pop in the same cycle, count=3 -> next cycle count=0, out_valid_1=0, all outputs 0. The following push_1 appears normally one cycle later.
- Steady state count=2, push_1&push_2 with pop_1&pop_2 in the same cycle -> count stays 2, outputs show the newly pushed pair one cycle later. At count=DEPTH-1 with pop_1 and push_1, the push is dropped (full registered) and count becomes DEPTH-2.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Dual-lane instruction queue between fetch and decode.
// Fetch pushes 0, 1 or 2 instructions per cycle into a circular buffer.
// Decode sees the two oldest entries and pops 0, 1 or 2 of them.
// A flush discards everything on a branch redirect or exception.
// All outputs are decoded from registered state only, so no input reaches an output combinationally.
module inst_fetch_queue #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push_1,
    input  logic                    push_2,
    input  logic [DATA_W-1:0]       push_data_1,
    input  logic [DATA_W-1:0]       push_data_2,
    input  logic [ADDR_W-1:0]       push_addr_1,
    input  logic [ADDR_W-1:0]       push_addr_2,
    input  logic                    pop_1,
    input  logic                    pop_2,
    output logic                    out_valid_1,
    output logic [DATA_W-1:0]       out_data_1,
    output logic [ADDR_W-1:0]       out_addr_1,
    output logic                    out_valid_2,
    output logic [DATA_W-1:0]       out_data_2,
    output logic [ADDR_W-1:0]       out_addr_2,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    push_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_p1;
    logic [PTR_W-1:0]  tail_p1;
    logic [CNT_W-1:0]  cnt_q;
    logic              drop_q;

    logic              push_ok;
    logic              pop_one;
    logic              pop_two;
    logic [1:0]        n_push;
    logic [1:0]        n_pop;

    // Decide how many entries are pushed and popped this cycle.
    // The decision uses the registered full flag and valid flags only.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        push_ok = 1'b0;
        pop_one = 1'b0;
        pop_two = 1'b0;
        n_push  = 2'd0;
        n_pop   = 2'd0;
        head_p1 = head + PTR_W'(1);
        tail_p1 = tail + PTR_W'(1);

        // Lane 2 alone is not a legal push, so it is treated as no push.
        // A full queue still has room for two entries in the cycle it clears, but pushes wait for that to be registered.
        push_ok = push_1 && !full;
        if (push_ok) begin
            n_push = push_2 ? 2'd2 : 2'd1;
        end

        // Pops on lanes that show no valid entry are ignored.
        // pop_2 counts only together with pop_1.
        pop_one = pop_1 && out_valid_1;
        pop_two = pop_one && pop_2 && out_valid_2;
        if (pop_two) begin
            n_pop = 2'd2;
        end else if (pop_one) begin
            n_pop = 2'd1;
        end
    end

    // Pointer, occupancy and drop-pulse registers.
    // rst takes priority over flush, and flush over push and pop.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop samples the values from before the edge.
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            head   <= head + PTR_W'(n_pop);
            tail   <= tail + PTR_W'(n_push);
            cnt_q  <= cnt_q + CNT_W'(n_push) - CNT_W'(n_pop);
            drop_q <= push_1 && full;
        end
    end

    // Entry storage. Lane 1 is written at tail and lane 2 at tail+1, so lane 1 is always older.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The valid flags come from cnt_q, and data is masked to 0 while invalid, so stale contents are never seen.
        if (!rst && !flush && push_ok) begin
            mem_data[tail] <= push_data_1;
            mem_addr[tail] <= push_addr_1;
            if (push_2) begin
                mem_data[tail_p1] <= push_data_2;
                mem_addr[tail_p1] <= push_addr_2;
            end
        end
    end

    // Output decode from registered state; data and address read as 0 on any invalid lane.
    always_comb begin
        count       = cnt_q;
        empty       = (cnt_q == '0);
        full        = (cnt_q > CNT_W'(DEPTH - 2));
        out_valid_1 = (cnt_q >= CNT_W'(1));
        out_valid_2 = (cnt_q >= CNT_W'(2));
        push_drop   = drop_q;
        out_data_1  = '0;
        out_addr_1  = '0;
        out_data_2  = '0;
        out_addr_2  = '0;
        if (out_valid_1) begin
            out_data_1 = mem_data[head];
            out_addr_1 = mem_addr[head];
        end
        if (out_valid_2) begin
            out_data_2 = mem_data[head_p1];
            out_addr_2 = mem_addr[head_p1];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue with DEPTH=4.
// The reference model is a plain queue of {data, addr} entries updated by the queue rules each cycle.
// Directed scenarios are followed by a randomized run checked against the model.
module tb_inst_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SNAP_W = 5 + 2 * (DATA_W + ADDR_W) + CNT_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst, flush, push_1, push_2, pop_1, pop_2;
    logic [DATA_W-1:0] push_data_1, push_data_2;
    logic [ADDR_W-1:0] push_addr_1, push_addr_2;
    logic              out_valid_1, out_valid_2, full, empty, push_drop;
    logic [DATA_W-1:0] out_data_1, out_data_2;
    logic [ADDR_W-1:0] out_addr_1, out_addr_2;
    logic [CNT_W-1:0]  count;
    logic [SNAP_W-1:0] dut_snap;

    int checks = 0;
    int errors = 0;

    entry_t model_q[$];
    logic   model_drop = 1'b0;

    inst_fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_1(push_1), .push_2(push_2),
        .push_data_1(push_data_1), .push_data_2(push_data_2),
        .push_addr_1(push_addr_1), .push_addr_2(push_addr_2),
        .pop_1(pop_1), .pop_2(pop_2),
        .out_valid_1(out_valid_1), .out_data_1(out_data_1), .out_addr_1(out_addr_1),
        .out_valid_2(out_valid_2), .out_data_2(out_data_2), .out_addr_2(out_addr_2),
        .full(full), .empty(empty), .count(count), .push_drop(push_drop)
    );

    always #5 clk = ~clk;

    assign dut_snap = {out_valid_1, out_data_1, out_addr_1, out_valid_2, out_data_2, out_addr_2,
                       count, full, empty, push_drop};

    // Expected output image derived from the model queue.
    function automatic logic [SNAP_W-1:0] model_snap();
        entry_t e1 = '0;
        entry_t e2 = '0;
        int n;
        n = model_q.size();
        if (n >= 1) e1 = model_q[0];
        if (n >= 2) e2 = model_q[1];
        return {n >= 1, e1.data, e1.addr, n >= 2, e2.data, e2.addr,
                CNT_W'(n), (DEPTH - n) < 2, n == 0, model_drop};
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; push_1 = 1'b0; push_2 = 1'b0; pop_1 = 1'b0; pop_2 = 1'b0;
        push_data_1 = '0; push_data_2 = '0; push_addr_1 = '0; push_addr_2 = '0;
    endtask

    task automatic set_push(input logic two, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        push_1 = 1'b1; push_2 = two;
        push_addr_1 = a1; push_data_1 = ~a1;
        push_addr_2 = a2; push_data_2 = ~a2;
    endtask

    // Apply the current inputs for one clock edge, advance the model, then settle and idle the inputs.
    task automatic step();
        int  n;
        bit  was_full;
        assert (!(push_2 && !push_1)) else $error("bench drove push_2 without push_1");
        n = model_q.size();
        was_full = (DEPTH - n) < 2;
        @(posedge clk);
        if (rst || flush) begin
            model_q.delete();
            model_drop = 1'b0;
        end else begin
            if (pop_1 && n >= 1) void'(model_q.pop_front());
            if (pop_1 && pop_2 && n >= 2) void'(model_q.pop_front());
            if (push_1 && !was_full) begin
                model_q.push_back(entry_t'{push_data_1, push_addr_1});
                if (push_2) model_q.push_back(entry_t'{push_data_2, push_addr_2});
            end
            model_drop = push_1 && was_full;
        end
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1; set_push(1'b1, 32'h40, 32'h44); pop_1 = 1'b1;
        step();
        checks++;
        if ({out_valid_1, out_valid_2, full, empty, push_drop, count} !== {5'b00010, CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_flags: got v1=%b v2=%b full=%b empty=%b drop=%b count=%0d, expected 0 0 0 1 0 0",
                     out_valid_1, out_valid_2, full, empty, push_drop, count);
        end
        checks++;
        if ({out_data_1, out_addr_1, out_data_2, out_addr_2} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, expected all zero", out_data_1, out_addr_1, out_data_2, out_addr_2);
        end
    endtask

    task automatic test_single_push();
        push_1 = 1'b1; push_data_1 = 32'h24020001; push_addr_1 = 32'hBFC00000;
        #1;
        checks++;
        if (out_valid_1 !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: got out_valid_1=%b in push cycle, expected 0", out_valid_1);
        end
        step();
        checks++;
        if ({out_valid_1, out_data_1, out_addr_1, out_valid_2, count, empty} !==
            {1'b1, 32'h24020001, 32'hBFC00000, 1'b0, CNT_W'(1), 1'b0}) begin
            errors++;
            $display("FAIL single_push: got v1=%b d1=%h a1=%h v2=%b count=%0d empty=%b, expected 1 24020001 bfc00000 0 1 0",
                     out_valid_1, out_data_1, out_addr_1, out_valid_2, count, empty);
        end
        flush = 1'b1;
        step();
    endtask

    task automatic test_full_drop();
        set_push(1'b1, 32'h100, 32'h104); step();
        set_push(1'b1, 32'h108, 32'h10C); step();
        checks++;
        if ({count, full, out_addr_1, out_addr_2} !== {CNT_W'(4), 1'b1, 32'h100, 32'h104}) begin
            errors++;
            $display("FAIL fill: got count=%0d full=%b a1=%h a2=%h, expected 4 1 100 104", count, full, out_addr_1, out_addr_2);
        end
        set_push(1'b0, 32'h110, 32'h0); step();
        checks++;
        if ({push_drop, count, out_addr_1} !== {1'b1, CNT_W'(4), 32'h100}) begin
            errors++;
            $display("FAIL drop_pulse: got drop=%b count=%0d a1=%h, expected 1 4 100", push_drop, count, out_addr_1);
        end
        step();
        checks++;
        if ({push_drop, count} !== {1'b0, CNT_W'(4)}) begin
            errors++;
            $display("FAIL drop_one_cycle: got drop=%b count=%0d, expected 0 4", push_drop, count);
        end
    endtask

    task automatic test_dual_pop();
        pop_1 = 1'b1; step();
        pop_1 = 1'b1; pop_2 = 1'b1; step();
        checks++;
        if ({count, out_addr_1, out_valid_2} !== {CNT_W'(1), 32'h10C, 1'b0}) begin
            errors++;
            $display("FAIL dual_pop: got count=%0d a1=%h v2=%b, expected 1 10c 0", count, out_addr_1, out_valid_2);
        end
        pop_1 = 1'b1; pop_2 = 1'b1; step();
        checks++;
        if ({count, empty, out_valid_1} !== {CNT_W'(0), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL underflow: got count=%0d empty=%b v1=%b, expected 0 1 0", count, empty, out_valid_1);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] want;
        set_push(1'b0, 32'h200, 32'h0); step();
        for (int k = 1; k <= 10; k++) begin
            set_push(1'b0, 32'h200 + ADDR_W'(4 * k), 32'h0);
            pop_1 = 1'b1;
            step();
            want = 32'h200 + ADDR_W'(4 * k);
            checks++;
            if ({count, out_addr_1, out_data_1} !== {CNT_W'(1), want, ~want}) begin
                errors++;
                $display("FAIL wrap_%0d: got count=%0d a1=%h d1=%h, expected 1 %h %h", k, count, out_addr_1, out_data_1, want, ~want);
            end
        end
        pop_1 = 1'b1; step();
    endtask

    task automatic test_flush();
        set_push(1'b1, 32'h500, 32'h504); step();
        set_push(1'b0, 32'h508, 32'h0); step();
        flush = 1'b1; set_push(1'b1, 32'h50C, 32'h510); pop_1 = 1'b1; pop_2 = 1'b1;
        step();
        checks++;
        if (dut_snap !== '0 && {count, empty} !== {CNT_W'(0), 1'b1}) begin
            errors++;
            $display("FAIL flush_count: got count=%0d empty=%b, expected 0 1", count, empty);
        end else if ({out_valid_1, out_valid_2, out_data_1, out_addr_1, out_data_2, out_addr_2, push_drop, full} !== '0) begin
            errors++;
            $display("FAIL flush_outputs: got v1=%b v2=%b d1=%h a1=%h drop=%b full=%b, expected all 0",
                     out_valid_1, out_valid_2, out_data_1, out_addr_1, push_drop, full);
        end
        set_push(1'b0, 32'h300, 32'h0); step();
        checks++;
        if ({out_valid_1, out_addr_1, count} !== {1'b1, 32'h300, CNT_W'(1)}) begin
            errors++;
            $display("FAIL after_flush: got v1=%b a1=%h count=%0d, expected 1 300 1", out_valid_1, out_addr_1, count);
        end
        flush = 1'b1; step();
    endtask

    task automatic test_back_to_back();
        set_push(1'b1, 32'h600, 32'h604); step();
        set_push(1'b1, 32'h608, 32'h60C); pop_1 = 1'b1; pop_2 = 1'b1; step();
        checks++;
        if ({count, out_addr_1, out_addr_2} !== {CNT_W'(2), 32'h608, 32'h60C}) begin
            errors++;
            $display("FAIL back_to_back: got count=%0d a1=%h a2=%h, expected 2 608 60c", count, out_addr_1, out_addr_2);
        end
        set_push(1'b0, 32'h610, 32'h0); step();
        checks++;
        if ({count, full} !== {CNT_W'(DEPTH - 1), 1'b1}) begin
            errors++;
            $display("FAIL near_full: got count=%0d full=%b, expected %0d 1", count, full, DEPTH - 1);
        end
        set_push(1'b0, 32'h614, 32'h0); pop_1 = 1'b1; step();
        checks++;
        if ({count, push_drop, out_addr_1, out_addr_2} !== {CNT_W'(DEPTH - 2), 1'b1, 32'h60C, 32'h610}) begin
            errors++;
            $display("FAIL full_registered: got count=%0d drop=%b a1=%h a2=%h, expected %0d 1 60c 610",
                     count, push_drop, out_addr_1, out_addr_2, DEPTH - 2);
        end
    endtask

    task automatic test_random();
        int push_pct;
        int pop_pct;
        for (int cyc = 0; cyc < 400; cyc++) begin
            push_pct = (cyc < 200) ? 75 : 35;
            pop_pct  = (cyc < 200) ? 35 : 75;
            if ($urandom_range(99) < push_pct) begin
                set_push($urandom_range(1) == 1, $urandom, $urandom);
                push_data_1 = $urandom; push_data_2 = $urandom;
            end
            pop_1 = $urandom_range(99) < pop_pct;
            pop_2 = $urandom_range(1) == 1;
            flush = $urandom_range(40) == 0;
            step();
            checks++;
            if (dut_snap !== model_snap()) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h (v1,d1,a1,v2,d2,a2,count,full,empty,drop)",
                         cyc, dut_snap, model_snap());
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_push();
        test_full_drop();
        test_dual_pop();
        test_wrap();
        test_flush();
        test_back_to_back();
        checks++;
        if (dut_snap !== model_snap()) begin
            errors++;
            $display("FAIL model_sync: got %h expected %h", dut_snap, model_snap());
        end
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
